wave_gen_dds: RTL and testbench
===============================

Name: wave_gen_dds

Overview:
Programmable DDS test-signal generator. It drives 8-bit DAC samples (DC, square, sawtooth, triangle) at a given frequency between programmable min and max codes. Its output is the stimulus that the scope front end's min/max/frequency measurement path quantifies. Configuration arrives through a valid/ready handshake and takes effect only at a phase wrap, so the output never glitches mid-period.

Parameters:
PHASE_W, 32, phase accumulator width; top 8 bits form the waveform index t
LATENCY, 3, fixed pipeline depth (accumulator, shaper, scaler); informational only, not meant to be changed

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
en  input  1  run enable; low holds the phase at 0
cfg_valid  input  1  configuration offered
cfg_ready  output  1  no pending configuration; a new one can be accepted
cfg_fword  input  PHASE_W  phase increment per clock
cfg_min  input  8  lowest output code
cfg_max  input  8  highest output code
cfg_wave  input  2  0 = DC, 1 = square, 2 = sawtooth, 3 = triangle
cfg_err  output  1  one-cycle pulse: offered configuration rejected
dac_data  output  8  sample to DAC
dac_valid  output  1  dac_data is from an enabled phase
phase_wrap  output  1  one-cycle pulse aligned with the first sample of a new period

Behaviour:
- Reset: all registers clear asynchronously on rst low.
  - Outputs after reset: dac_data = 0, dac_valid = 0, phase_wrap = 0, cfg_err = 0, cfg_ready = 1.
  - Active config after reset: fword = 0, min = 0, max = 255, wave = 0.
  - Pending config is cleared. Reset mid-operation discards any pending config.
- Handshake:
  - A transfer occurs when cfg_valid and cfg_ready are both high.
  - If cfg_min > cfg_max: cfg_err pulses on the next cycle, nothing is latched, and cfg_ready stays 1.
  - Otherwise the offered values are latched into the pending registers and cfg_ready drops to 0 on the next cycle.
  - cfg_ready returns to 1 on the cycle after the pending config is applied.
- Applying the pending config: it is copied into the active registers on the first cycle where any of the following holds:
  - (a) the accumulator addition carries out of bit PHASE_W-1;
  - (b) en = 0;
  - (c) the active fword = 0.
- Stage 1 (accumulator):
  - If en = 1: acc <= acc + active fword, modulo 2^PHASE_W. Carry-out sets the wrap flag for that sample.
  - If en = 0: acc <= 0 and the wrap flag is 0.
  - The fword applied on a wrap cycle takes effect from the next addition.
- Config alignment: each sample carries a snapshot of {min, max, wave}, taken when the sample enters stage 1. This snapshot travels with the sample through the pipeline, so a config change affects whole samples only.
- Stage 2 (shaper): t = acc[PHASE_W-1 : PHASE_W-8].
  - DC: raw = 0.
  - Square: raw = t[7] ? 255 : 0.
  - Sawtooth: raw = t.
  - Triangle: raw = t[7] ? ~{t[6:0], 0} : {t[6:0], 0}.
- Stage 3 (scaler):
  - span = max - min + 1, 9-bit value in the range 1..256.
  - prod = span * raw, 17 bits.
  - dac_data = min + prod[15:8], computed 9 bits wide. The result is guaranteed to be ≤ max; truncate to 8 bits.
- Timing:
  - Latency is 3 cycles from the acc update to dac_data.
  - dac_valid and phase_wrap are en and the wrap flag, each delayed to align with dac_data.
  - With en low, dac_data settles to min (raw = 0 for t = 0 in every waveform).
- Boundary behaviour:
  - fword = 0 with en high: constant output. A pending config applies through condition (c).
  - min = max: output is constant min.
  - cfg_valid on the same cycle as an apply: ready is still 0, so there is no transfer. The master must hold valid.
  - Wrap and apply coincide: the new fword is used for the next addition. The current sample keeps its own snapshot.

Test Plan:
- Reset, then en = 1, configure fword = 0x0100_0000, wave = 2, min = 0, max = 255 -> cfg applies immediately (active fword is 0). dac_data ramps 0, 1, …, 255, 0 with a 256-cycle period. phase_wrap pulses once per period, aligned with sample 0.
- wave = 1, min = 50, max = 200, fword = 0x0200_0000 -> output is 64 cycles at 50 followed by 64 cycles at 200 (50 + ((151 × 255) >> 8) = 200), repeating.
- wave = 3, min = 0, max = 255, fword = 0x0100_0000 -> output follows 0, 2, …, 254, 255, 253, …, 1. Never exceeds 255.
- Mid-period config (fword 0x0100_0000 → 0x0400_0000) while running -> cfg_ready = 0 until the next wrap. The old waveform completes its period unchanged. The new 64-cycle period starts exactly at the phase_wrap pulse. cfg_ready = 1 on the following cycle.
- Offer min = 100, max = 20 -> single cfg_err pulse, cfg_ready stays 1, output unaffected.
- Assert rst low mid-period with a config pending -> dac_data = 0, dac_valid = 0, cfg_ready = 1 immediately. After release with en = 1, output is constant 0 (DC defaults) and the pending config is gone.

Source files
------------

// File: rtl/wave_gen_dds.sv
// Programmable DDS test-signal generator: phase accumulator, waveform shaper and
// min/max scaler, with configuration that takes effect only at a phase wrap.
module wave_gen_dds #(
    parameter int PHASE_W = 32,
    parameter int LATENCY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fword,
    input  logic [7:0]         cfg_min,
    input  logic [7:0]         cfg_max,
    input  logic [1:0]         cfg_wave,
    output logic               cfg_err,
    output logic [7:0]         dac_data,
    output logic               dac_valid,
    output logic               phase_wrap
);

    logic [PHASE_W-1:0] act_fword, pend_fword, acc, acc_sum;
    logic [7:0]         act_min, act_max, pend_min, pend_max;
    logic [1:0]         act_wave, pend_wave;
    logic               pend_valid, carry, apply, xfer;

    logic [7:0]         s1_min, s1_max, s2_min, s2_max, s2_raw;
    logic [1:0]         s1_wave;
    logic [LATENCY-1:0] en_pipe, wrap_pipe;

    logic [7:0]         t, raw;
    logic [8:0]         span;
    logic [16:0]        prod;

    always_comb begin
        {carry, acc_sum} = {1'b0, acc} + {1'b0, act_fword};
        apply = pend_valid && ((en && carry) || !en || (act_fword == '0));
        xfer  = cfg_valid && !pend_valid;
    end

    assign cfg_ready = !pend_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_fword  <= '0;
            act_min    <= '0;
            act_max    <= '1;
            act_wave   <= '0;
            pend_fword <= '0;
            pend_min   <= '0;
            pend_max   <= '0;
            pend_wave  <= '0;
            pend_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= xfer && (cfg_min > cfg_max);
            // apply needs pend_valid and xfer needs !pend_valid, so they never coincide
            if (apply) begin
                act_fword  <= pend_fword;
                act_min    <= pend_min;
                act_max    <= pend_max;
                act_wave   <= pend_wave;
                pend_valid <= 1'b0;
            end else if (xfer && (cfg_min <= cfg_max)) begin
                pend_fword <= cfg_fword;
                pend_min   <= cfg_min;
                pend_max   <= cfg_max;
                pend_wave  <= cfg_wave;
                pend_valid <= 1'b1;
            end
        end
    end

    assign t = acc[PHASE_W-1 -: 8];

    always_comb begin
        raw = '0;
        case (s1_wave)
            2'd0: raw = '0;
            2'd1: raw = {8{t[7]}};
            2'd2: raw = t;
            2'd3: raw = t[7] ? ~{t[6:0], 1'b0} : {t[6:0], 1'b0};
            default: raw = '0;
        endcase
        span = {1'b0, s2_max} - {1'b0, s2_min} + 9'd1;
        prod = {8'd0, span} * {9'd0, s2_raw};
    end

    // Config snapshot rides alongside each sample so a change only affects whole samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            s1_min    <= '0;
            s1_max    <= '0;
            s1_wave   <= '0;
            s2_raw    <= '0;
            s2_min    <= '0;
            s2_max    <= '0;
            dac_data  <= '0;
            en_pipe   <= '0;
            wrap_pipe <= '0;
        end else begin
            acc          <= en ? acc_sum : '0;
            s1_min       <= act_min;
            s1_max       <= act_max;
            s1_wave      <= act_wave;
            s2_raw       <= raw;
            s2_min       <= s1_min;
            s2_max       <= s1_max;
            dac_data     <= s2_min + 8'(prod >> 8);
            en_pipe      <= {en_pipe[LATENCY-2:0], en};
            wrap_pipe    <= {wrap_pipe[LATENCY-2:0], en && carry};
        end
    end

    assign dac_valid  = en_pipe[LATENCY-1];
    assign phase_wrap = wrap_pipe[LATENCY-1];

endmodule

// File: tb/tb_wave_gen_dds.sv
// Randomized and directed bench for wave_gen_dds against a cycle-level reference model.
module tb_wave_gen_dds;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_fword = '0;
    logic [7:0]  cfg_min = '0;
    logic [7:0]  cfg_max = '0;
    logic [1:0]  cfg_wave = '0;
    logic        cfg_err;
    logic [7:0]  dac_data;
    logic        dac_valid;
    logic        phase_wrap;

    int checks = 0;
    int failures = 0;

    wave_gen_dds #(.PHASE_W(32), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fword(cfg_fword),
        .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_wave(cfg_wave), .cfg_err(cfg_err),
        .dac_data(dac_data), .dac_valid(dac_valid), .phase_wrap(phase_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: active/pending config, phase, and a 3-deep output delay line
    logic [31:0] m_fword, p_fword, m_phase;
    int          m_min, m_max, m_wave, p_min, p_max, p_wave;
    bit          m_pend, m_err;
    int          d_data[3];
    bit          d_val[3], d_wrap[3];

    function automatic int shape(input int wave, input int t);
        case (wave)
            1:       return (t >= 128) ? 255 : 0;
            2:       return t;
            3:       return (t < 128) ? 2 * t : 255 - 2 * (t - 128);
            default: return 0;
        endcase
    endfunction

    function automatic int sample(input int mn, input int mx, input int wave, input int t);
        return mn + ((mx - mn + 1) * shape(wave, t)) / 256;
    endfunction

    task automatic model_reset();
        m_fword = '0; m_min = 0; m_max = 255; m_wave = 0;
        p_fword = '0; p_min = 0; p_max = 0; p_wave = 0;
        m_pend = 1'b0; m_err = 1'b0; m_phase = '0;
        for (int i = 0; i < 3; i++) begin
            d_data[i] = 0; d_val[i] = 1'b0; d_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [32:0] nxt;
        bit carry, apply, accept, err;
        nxt    = {1'b0, m_phase} + {1'b0, m_fword};
        carry  = en && nxt[32];
        apply  = m_pend && (carry || !en || (m_fword == 0));
        m_phase = en ? nxt[31:0] : 32'd0;
        for (int i = 2; i > 0; i--) begin
            d_data[i] = d_data[i-1]; d_val[i] = d_val[i-1]; d_wrap[i] = d_wrap[i-1];
        end
        d_data[0] = sample(m_min, m_max, m_wave, int'(m_phase >> 24));
        d_val[0]  = en;
        d_wrap[0] = carry;
        err    = cfg_valid && !m_pend && (cfg_min > cfg_max);
        accept = cfg_valid && !m_pend && (cfg_min <= cfg_max);
        if (apply) begin
            m_fword = p_fword; m_min = p_min; m_max = p_max; m_wave = p_wave;
            m_pend = 1'b0;
        end
        if (accept) begin
            p_fword = cfg_fword; p_min = cfg_min; p_max = cfg_max; p_wave = cfg_wave;
            m_pend = 1'b1;
        end
        m_err = err;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("dac_data",   dac_data,   d_data[2]);
        check("dac_valid",  dac_valid,  d_val[2]);
        check("phase_wrap", phase_wrap, d_wrap[2]);
        check("cfg_ready",  cfg_ready,  !m_pend);
        check("cfg_err",    cfg_err,    m_err);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cfg(input logic [31:0] f, input logic [7:0] mn, input logic [7:0] mx,
                            input logic [1:0] w);
        logic rdy;
        int n;
        cfg_fword = f; cfg_min = mn; cfg_max = mx; cfg_wave = w; cfg_valid = 1'b1;
        n = 0;
        do begin
            rdy = cfg_ready;
            tick();
            n++;
        end while (!rdy && n < 1000);
        check("cfg_handshake", rdy, 1);
        cfg_valid = 1'b0;
    endtask

    int cnt_a, cnt_b;

    initial begin
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst_dac_data",   dac_data,   0);
        check("rst_dac_valid",  dac_valid,  0);
        check("rst_phase_wrap", phase_wrap, 0);
        check("rst_cfg_err",    cfg_err,    0);
        check("rst_cfg_ready",  cfg_ready,  1);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;

        // Sawtooth full scale: two wraps in any 512-cycle window
        en = 1'b1;
        run(3);
        send_cfg(32'h0100_0000, 8'd0, 8'd255, 2'd2);
        run(300);
        cnt_a = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (phase_wrap) cnt_a++;
        end
        check("saw_wraps_512", cnt_a, 2);

        // Square 50..200, 128-cycle period
        send_cfg(32'h0200_0000, 8'd50, 8'd200, 2'd1);
        run(300);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (dac_data == 8'd200) cnt_a++;
            if (dac_data == 8'd50) cnt_b++;
        end
        check("sq_hi_count", cnt_a, 64);
        check("sq_lo_count", cnt_b, 64);

        // Triangle full scale: 255 appears exactly once per period
        send_cfg(32'h0100_0000, 8'd0, 8'd255, 2'd3);
        run(400);
        cnt_a = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (dac_data == 8'd255) cnt_a++;
        end
        check("tri_peak_count", cnt_a, 1);

        // Mid-period frequency change waits for the wrap
        send_cfg(32'h0100_0000, 8'd0, 8'd255, 2'd2);
        run(400);
        send_cfg(32'h0400_0000, 8'd0, 8'd255, 2'd2);
        run(400);

        // Rejected configuration: one err pulse, nothing pending
        send_cfg(32'h0300_0000, 8'd100, 8'd20, 2'd1);
        check("bad_cfg_err_pulse", cfg_err, 1);
        check("bad_cfg_ready", cfg_ready, 1);
        tick();
        check("bad_cfg_err_clear", cfg_err, 0);
        run(50);

        // Reset with a configuration pending
        send_cfg(32'h0100_0000, 8'd0, 8'd255, 2'd2);
        run(30);
        send_cfg(32'h0080_0000, 8'd10, 8'd240, 2'd1);
        run(5);
        #3 rst = 1'b0;
        #1;
        check("midrst_dac_data",  dac_data,  0);
        check("midrst_dac_valid", dac_valid, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        model_reset();
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        run(60);
        check("post_rst_dc", dac_data, 0);

        // Randomized configs, enable toggling and invalid offers
        for (int k = 0; k < 40; k++) begin
            logic [7:0] a, b;
            logic [31:0] f;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) != 0 && a > b) begin
                logic [7:0] tmp;
                tmp = a; a = b; b = tmp;
            end
            case ($urandom_range(0, 3))
                0:       f = 32'($urandom_range(1, 8)) << 24;
                1:       f = '0;
                default: f = $urandom;
            endcase
            en = ($urandom_range(0, 5) != 0);
            send_cfg(f, a, b, 2'($urandom));
            run(int'($urandom_range(20, 150)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
